// File: rtl/smart_home_pkg.sv
// smart_home_pkg: shared constants and types for the home-state memory arbiter
// Provides: MEM_DATA_W, DEF_NUM_REQ, requester indices, arbiter state enum.
package smart_home_pkg;
  localparam int MEM_DATA_W  = 35;
  localparam int DEF_NUM_REQ = 3;
  localparam int REQ_SENSOR  = 0;
  localparam int REQ_PANEL   = 1;
  localparam int REQ_TIMER   = 2;
  typedef enum logic [1:0] {IDLE, WRITE, SETTLE} arb_state_e;
endpackage

// File: rtl/mem_write_arbiter_rr_picker.sv
// rr_picker: combinational pick of one request, searching upward from a start pointer
// Ports: i_req requests, i_ptr search start (< N), o_onehot/o_idx winner, o_valid any request.
module rr_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [2:0]   i_ptr,
  output logic [N-1:0] o_onehot,
  output logic [2:0]   o_idx,
  output logic         o_valid
);
  logic [N-1:0] w_rot;
  // Rotating the doubled vector puts the pointer's requester at bit 0.
  assign w_rot = N'({i_req, i_req} >> i_ptr);
  assign o_valid = |i_req;
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) o_idx = w_rot[k] ? 3'((k + int'(i_ptr)) % N) : o_idx;
  end
  assign o_onehot = o_valid ? N'(1) << o_idx : '0;
endmodule

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: masked read-modify-write arbiter sharing one memory word between requesters
// Ports: clk/arst (sync, active-high); req/req_data/req_mask per requester; ack pulse,
// grant_id, busy; mem_wren/mem_din to the memory, mem_dout from it.
// Build option: MEM_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module mem_write_arbiter
  import smart_home_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = MEM_DATA_W
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DATA_W-1:0] req_mask,
  output logic [NUM_REQ-1:0]        ack,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      mem_wren,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout
);
  arb_state_e r_state, w_next;
  logic [NUM_REQ-1:0] w_onehot;
  logic [2:0] w_idx, w_ptr;
  logic w_valid, w_go;
  logic [DATA_W-1:0] w_data, w_mask, w_merge;
`ifdef MEM_ARB_RR_EN
  logic [2:0] r_ptr;
  assign w_ptr = r_ptr;
  always_ff @(posedge clk)
    if (arst) r_ptr <= '0;
    else if (w_go) r_ptr <= (w_idx == 3'(NUM_REQ - 1)) ? '0 : w_idx + 3'd1;
`else
  assign w_ptr = '0;
`endif
  rr_picker #(.N(NUM_REQ)) u_pick (
    .i_req(req), .i_ptr(w_ptr), .o_onehot(w_onehot), .o_idx(w_idx), .o_valid(w_valid)
  );
  always_comb begin
    w_data = '0;
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_data = w_data | (w_onehot[i] ? req_data[i*DATA_W +: DATA_W] : '0);
      w_mask = w_mask | (w_onehot[i] ? req_mask[i*DATA_W +: DATA_W] : '0);
    end
    w_merge = (mem_dout & ~w_mask) | (w_data & w_mask);
    w_go = (r_state == IDLE) && w_valid;
    w_next = (r_state == WRITE) ? SETTLE : (w_go ? WRITE : IDLE);
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      r_state  <= IDLE;
      ack      <= '0;
      mem_wren <= 1'b0;
      mem_din  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      r_state  <= w_next;
      ack      <= w_go ? w_onehot : '0;
      mem_wren <= w_go;
      busy     <= w_next != IDLE;
      if (w_go) begin
        grant_id <= w_idx;
        mem_din  <= w_merge;
      end
    end
  end
endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb_mem_write_arbiter: scoreboard bench with a behavioural memory for mem_write_arbiter
module tb_mem_write_arbiter;
  import smart_home_pkg::*;
  localparam int N = DEF_NUM_REQ;
  localparam int W = MEM_DATA_W;
  typedef struct packed {
    logic [N-1:0] ack;
    logic [2:0]   gid;
    logic [W-1:0] din;
  } exp_t;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N*W-1:0] req_mask = '0;
  logic [N-1:0] ack;
  logic [2:0] grant_id;
  logic busy, mem_wren;
  logic [W-1:0] mem_din;
  logic [W-1:0] mem = '0;
  logic preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;
  logic prev_wren = 1'b0;
  exp_t q[$];
  exp_t e_m;
  int checks = 0;
  int errors = 0;
  int n_wr = 0;

  mem_write_arbiter dut (
    .clk(clk), .arst(arst), .req(req), .req_data(req_data), .req_mask(req_mask),
    .ack(ack), .grant_id(grant_id), .busy(busy), .mem_wren(mem_wren),
    .mem_din(mem_din), .mem_dout(mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_wren === 1'b1) mem <= mem_din;
    else if (preset_en) mem <= preset_val;

  always @(negedge clk) begin
    checks++;
    assert (mem_wren === 1'b1 || ack === '0) else begin
      errors++; $error("FAIL ack_without_wren ack=%b required=%b", ack, {N{1'b0}});
    end
    if (mem_wren === 1'b1) begin
      checks++;
      assert (prev_wren === 1'b0) else begin
        errors++; $error("FAIL wren_back_to_back prev=%b required=0", prev_wren);
      end
      checks++;
      assert (q.size() > 0) else begin
        errors++; $error("FAIL unexpected_write ack=%b din=%h required=no_write", ack, mem_din);
      end
      if (q.size() > 0) begin
        e_m = q.pop_front();
        checks++;
        assert ({busy, ack, grant_id, mem_din} === {1'b1, e_m.ack, e_m.gid, e_m.din}) else begin
          errors++;
          $error("FAIL write_cycle busy/ack/gid/din=%b/%b/%0d/%h required=1/%b/%0d/%h",
                 busy, ack, grant_id, mem_din, e_m.ack, e_m.gid, e_m.din);
        end
      end
      n_wr++;
    end
    prev_wren = mem_wren;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] d,
                                         input logic [W-1:0] m);
    return (o & ~m) | (d & m);
  endfunction

  task automatic set_mem(input logic [W-1:0] v);
    preset_val = v;
    preset_en = 1'b1;
    @(negedge clk);
    preset_en = 1'b0;
  endtask

  task automatic wait_wr(input int target, input string tag, output int cyc);
    cyc = 0;
    while (n_wr < target && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    assert (n_wr >= target) else begin
      errors++; $error("FAIL %s_timeout writes=%0d required=%0d", tag, n_wr, target);
    end
  endtask

  task automatic do_write(input int i, input logic [W-1:0] d, input logic [W-1:0] m,
                          input logic [W-1:0] exp_din, input string tag);
    int base;
    int cyc;
    base = n_wr;
    req_data[i*W +: W] = d;
    req_mask[i*W +: W] = m;
    q.push_back(exp_t'{ack: N'(1) << i, gid: 3'(i), din: exp_din});
    req[i] = 1'b1;
    wait_wr(base + 1, tag, cyc);
    req[i] = 1'b0;
    checks++;
    assert (cyc === 1) else begin
      errors++; $error("FAIL %s_latency cycles=%0d required=1", tag, cyc);
    end
    tick(3);
    checks++;
    assert (mem === exp_din) else begin
      errors++; $error("FAIL %s_mem mem=%h required=%h", tag, mem, exp_din);
    end
  endtask

  initial begin
    int base;
    int cyc;
    int ord[4];
`ifdef MEM_ARB_RR_EN
    ord = '{0, 1, 2, 0};
`else
    ord = '{0, 0, 0, 0};
`endif
    tick(2);
    arst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      assert ({mem_wren, ack, busy, grant_id, mem_din} === '0) else begin
        errors++;
        $error("FAIL idle wren/ack/busy/gid/din=%b/%b/%b/%0d/%h required=all_zero",
               mem_wren, ack, busy, grant_id, mem_din);
      end
    end
    set_mem(35'h0);
    do_write(REQ_PANEL, 35'h7_FFFF_FFFF, 35'h0_0000_00FF, 35'h0_0000_00FF, "masked");
    set_mem(35'h1_2345_6789);
    do_write(REQ_SENSOR, 35'h0, 35'h0_0000_000F, 35'h1_2345_6780, "rmw");
    set_mem(35'h3_0F0F_0F0F);
    do_write(REQ_PANEL, 35'h4_A5A5_A5A5, 35'h6_FF00_00FF,
             merge(35'h3_0F0F_0F0F, 35'h4_A5A5_A5A5, 35'h6_FF00_00FF), "mixed");
    set_mem(35'h5_5555_5555);
    do_write(REQ_TIMER, 35'h7_FFFF_FFFF, 35'h0, 35'h5_5555_5555, "zero_mask");
    set_mem(35'h5_5555_5555);
    do_write(REQ_TIMER, 35'h2_AAAA_AAAA, 35'h7_FFFF_FFFF, 35'h2_AAAA_AAAA, "full_mask");

    base = n_wr;
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = 35'(i + 1) * 35'h0_1111_1111;
      req_mask[i*W +: W] = '1;
    end
    for (int k = 0; k < 4; k++)
      q.push_back(exp_t'{ack: N'(1) << ord[k], gid: 3'(ord[k]), din: 35'(ord[k] + 1) * 35'h0_1111_1111});
    req = '1;
    wait_wr(base + 4, "contend", cyc);
    req = '0;
    tick(4);
    checks++;
    assert (n_wr == base + 4 && q.size() == 0) else begin
      errors++; $error("FAIL contend_count writes=%0d pending=%0d required=%0d/0", n_wr - base, q.size(), 4);
    end

    base = n_wr;
    req_data[REQ_TIMER*W +: W] = 35'h0_0000_1234;
    q.push_back(exp_t'{ack: N'(1) << REQ_TIMER, gid: 3'(REQ_TIMER), din: 35'h0_0000_1234});
    req[REQ_TIMER] = 1'b1;
    wait_wr(base + 1, "rst_mid", cyc);
    arst = 1'b1;
    req = '0;
    @(negedge clk);
    checks++;
    assert ({mem_wren, ack, busy, grant_id} === '0) else begin
      errors++;
      $error("FAIL rst_mid wren/ack/busy/gid=%b/%b/%b/%0d required=0/000/0/0", mem_wren, ack, busy, grant_id);
    end
    arst = 1'b0;
    tick(2);

    base = n_wr;
    set_mem(35'h0_0F0F_0000);
    req_data[REQ_SENSOR*W +: W] = 35'h0_0000_00AA;
    req_mask[REQ_SENSOR*W +: W] = 35'h0_0000_00FF;
    req_data[REQ_PANEL*W +: W] = 35'h7_0000_0000;
    q.push_back(exp_t'{ack: N'(1) << REQ_SENSOR, gid: 3'(REQ_SENSOR), din: 35'h0_0F0F_00AA});
    req = 3'b011;
    wait_wr(base + 1, "late_drop", cyc);
    req = '0;
    tick(8);
    checks++;
    assert (n_wr == base + 1 && q.size() == 0) else begin
      errors++; $error("FAIL late_drop writes=%0d pending=%0d required=1/0", n_wr - base, q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
